booth_mult_radix2: RTL and testbench
====================================

# booth_mult_radix2

Sequential signed multiplier using radix-2 Booth recoding. It accepts two L_word-bit two's-complement operands on a start strobe and iterates one Booth step per clock. It returns the 2*L_word-bit signed product with a ready flag. It is a reusable arithmetic block for datapaths where area matters more than latency.

## Interface
- L_word, default 4: operand width in bits; must be at least 2.
- clk  input  1: rising-edge clock.
- rst_n  input  1: reset, asynchronous and active-high. The block is in reset when rst_n = 1, despite the suffix.
- word1  input  L_word: multiplicand, two's complement. Only the low L_word bits are used.
- word2  input  L_word: multiplier, two's complement.
- start  input  1: operation request, sampled on the rising edge of clk.
- product  output  2*L_word: signed product word1*word2, registered.
- err  output  1: protocol error flag, registered.
- ready  output  1: result valid, registered.

## Operation
- States: IDLE, CALC, DONE. Reset enters IDLE.
- Reset values: product = 0, ready = 0, err = 0. All internal registers clear, including counter, A, Q and q_m1.
- Accept rule: start is accepted in IDLE or DONE.
  - On the accepting edge, M <= word1 and A <= 0 (L_word+1 bits).
  - Q <= word2, q_m1 <= 0, counter <= 0.
  - ready <= 0, err <= 0, next state CALC.
- CALC step, one per cycle, based on {Q[0], q_m1}:
  - 01: A <= A + sx(M).
  - 10: A <= A - sx(M).
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A, Q, q_m1} by one bit.
  - A is L_word+1 bits so that the operand −2^(L_word−1) cannot overflow. Example: 0 − (−8) = +8 must fit for L_word = 4.
- After L_word steps:
  - product <= {A[L_word-1:0], Q} taken from the shifted value.
  - ready <= 1, next state DONE.
- DONE: ready and product hold until the next accepted start or reset.
- Start while in CALC: ignored, and the operation continues unaffected. Err behaviour is set in Configuration.
- Start held high continuously: a new operation is accepted on every edge in DONE. This gives back-to-back operations with ready high for exactly one cycle each.
- Operand changes after the accepting edge have no effect.
- Reset asserted mid-operation: the block aborts immediately (asynchronously) to IDLE with reset values. The result is discarded.
- Full range is exact, including (−2^(L_word−1))² = +2^(2·L_word−2). Example: for L_word = 4, −8 × −8 = 64 = 8'h40.

## Timing
- Latency: ready rises on the L_word-th rising edge after the accepting edge. For L_word = 4 that is 4 edges.
- Throughput: one result per L_word+1 cycles when start is held.
- ready falls on the accepting edge, so a bench may drive a one-cycle start pulse and then wait for ready high.
- product is stable whenever ready = 1.

## Configuration
- Macro MBOOTH_ERR_EN.
- Defined:
  - err <= 1 on any edge where start = 1 in CALC.
  - err is sticky until the next accepted start or reset.
- Undefined: err is tied to 0 and the error logic is removed.

## Structure
- Package booth_mult_pkg:
  - State enum typedef (IDLE, CALC, DONE).
  - Booth op enum (NOP, ADD, SUB) decoded from {Q[0], q_m1}.
- One natural sub-module, booth_step: a combinational add/subtract plus arithmetic-shift datapath for a single iteration, parameterised by L_word.
- The top level holds the FSM, the counter (clog2(L_word+1) bits) and the output registers.

## Test plan
- Exhaustive sweep, L_word = 4: all 256 pairs (word1, word2) in −8..7, each with a 1-cycle start pulse.
  - Expected: product equals the signed product after ready, e.g. 3 × −5 = 8'hF1 and 7 × 7 = 8'h31.
- Corner values:
  - −8 × −8 gives 8'h40.
  - −8 × 7 gives 8'hC8.
  - 0 × −8 gives 8'h00.
  - In every case ready rises exactly 4 edges after the accepting edge.
- Start pulse mid-CALC: result unchanged.
  - With MBOOTH_ERR_EN: err = 1 until the next accepted start.
  - Without MBOOTH_ERR_EN: err stays 0.
- Start held high for 3 operations: three results, each with ready high for 1 cycle and correct product.
- Reset asserted during cycle 2 of CALC: product, ready and err are 0 immediately. The next operation (5 × 6) completes with 8'h1E.

Source files
------------

// File: rtl/booth_mult_pkg.sv
// booth_mult_pkg: shared FSM state and Booth recoding types for booth_mult_radix2
package booth_mult_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [1:0] {NOP, ADD, SUB} op_t;
    function automatic op_t booth_op(input logic q0, input logic qm1);
        return (q0 == qm1) ? NOP : (q0 ? SUB : ADD);
    endfunction
endpackage

// File: rtl/booth_mult_radix2_if.sv
// booth_mult_radix2_if: operand/start request and product/ready/err response bundle
interface booth_mult_radix2_if #(parameter int L_word = 4);
    logic [L_word-1:0] word1;
    logic [L_word-1:0] word2;
    logic start;
    logic [2*L_word-1:0] product;
    logic err;
    logic ready;
    modport master(output word1, word2, start, input product, err, ready);
    modport slave(input word1, word2, start, output product, err, ready);
endinterface

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration, add/sub of sign-extended M then arithmetic right shift
module booth_step import booth_mult_pkg::*; #(parameter int L_word = 4) (
    input  logic [L_word:0]   a_i,
    input  logic [L_word-1:0] q_i,
    input  logic              qm1_i,
    input  logic [L_word-1:0] m_i,
    output logic [L_word:0]   a_o,
    output logic [L_word-1:0] q_o,
    output logic              qm1_o
);
    logic [L_word:0] mx;
    logic [L_word:0] sum;
    op_t op;
    always_comb begin
        op = booth_op(q_i[0], qm1_i);
        mx = {m_i[L_word-1], m_i};
        sum = (op == ADD) ? a_i + mx : (op == SUB) ? a_i - mx : a_i;
        {a_o, q_o, qm1_o} = {sum[L_word], sum, q_i};
    end
endmodule

// File: rtl/booth_mult_radix2.sv
// booth_mult_radix2: sequential radix-2 Booth signed multiplier, one step per clock
// Optional sticky protocol-error flag when MBOOTH_ERR_EN is defined.
module booth_mult_radix2 import booth_mult_pkg::*; #(parameter int L_word = 4) (
    input logic clk,
    input logic rst_n,
    booth_mult_radix2_if.slave bus
);
    localparam int CW = $clog2(L_word + 1);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [L_word-1:0] m_q, m_d, q_q, q_d, q_s;
    logic [L_word:0] a_q, a_d, a_s;
    logic qm1_q, qm1_d, qm1_s;
    logic [2*L_word-1:0] product_q, product_d;
    logic ready_q, ready_d;
    logic accept, calc, last;
    assign accept = bus.start && (state_q != CALC);
    assign calc = (state_q == CALC);
    assign last = calc && (cnt_q == CW'(L_word - 1));
    booth_step #(.L_word(L_word)) u_step (
        .a_i(a_q), .q_i(q_q), .qm1_i(qm1_q), .m_i(m_q),
        .a_o(a_s), .q_o(q_s), .qm1_o(qm1_s)
    );
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            product_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            product_q <= product_d;
            ready_q   <= ready_d;
        end
    end
    always_comb begin
        state_d = accept ? CALC : last ? DONE : state_q;
    end
    // Product is taken from the post-shift value of the final step, not from A/Q registers.
    always_comb begin
        m_d       = accept ? bus.word1 : m_q;
        a_d       = accept ? '0 : calc ? a_s : a_q;
        q_d       = accept ? bus.word2 : calc ? q_s : q_q;
        qm1_d     = accept ? 1'b0 : calc ? qm1_s : qm1_q;
        cnt_d     = accept ? '0 : calc ? cnt_q + CW'(1) : cnt_q;
        product_d = last ? {a_s[L_word-1:0], q_s} : product_q;
        ready_d   = accept ? 1'b0 : last ? 1'b1 : ready_q;
    end
    assign bus.product = product_q;
    assign bus.ready   = ready_q;
`ifdef MBOOTH_ERR_EN
    logic err_q, err_d;
    always_comb begin
        err_d = accept ? 1'b0 : (calc && bus.start) ? 1'b1 : err_q;
    end
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) err_q <= 1'b0;
        else err_q <= err_d;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_booth_mult_radix2.sv
// tb_booth_mult_radix2: scoreboard bench for booth_mult_radix2 at L_word = 4
module tb_booth_mult_radix2;
    localparam int L = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [2*L-1:0] sb[$];
    booth_mult_radix2_if #(.L_word(L)) bus ();
    booth_mult_radix2 #(.L_word(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic issue(input int a, input int b);
        logic [31:0] av, bv, p;
        av = a;
        bv = b;
        p = a * b;
        @(negedge clk);
        bus.word1 = av[L-1:0];
        bus.word2 = bv[L-1:0];
        bus.start = 1'b1;
        sb.push_back(p[2*L-1:0]);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_ready(output int edges);
        edges = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic pop_exp(output logic [2*L-1:0] e);
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
    endtask

    task automatic test_reset();
        bus.word1 = '0;
        bus.word2 = '0;
        bus.start = 1'b0;
        rst_n = 1'b1;
        #12;
        checks++;
        if (bus.product !== 8'h00) begin errors++; $display("FAIL reset_product got=%h want=00", bus.product); end
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", bus.ready); end
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", bus.err); end
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_sweep();
        int edges;
        logic [2*L-1:0] e;
        for (int a = -8; a < 8; a++) begin
            for (int b = -8; b < 8; b++) begin
                issue(a, b);
                checks++;
                if (bus.ready !== 1'b0) begin errors++; $display("FAIL sweep_ready_fall a=%0d b=%0d got=%b want=0", a, b, bus.ready); end
                wait_ready(edges);
                pop_exp(e);
                checks++;
                if (edges != L) begin errors++; $display("FAIL sweep_latency a=%0d b=%0d got=%0d want=%0d", a, b, edges, L); end
                checks++;
                if (bus.product !== e) begin errors++; $display("FAIL sweep_product a=%0d b=%0d got=%h want=%h", a, b, bus.product, e); end
            end
        end
    endtask

    task automatic test_corners();
        int ta[5] = '{-8, -8, 0, 3, 7};
        int tb[5] = '{-8, 7, -8, -5, 7};
        logic [7:0] tp[5] = '{8'h40, 8'hC8, 8'h00, 8'hF1, 8'h31};
        int edges;
        logic [2*L-1:0] e;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i]);
            wait_ready(edges);
            pop_exp(e);
            checks++;
            if (edges != L) begin errors++; $display("FAIL corner_latency i=%0d got=%0d want=%0d", i, edges, L); end
            checks++;
            if (bus.product !== tp[i]) begin errors++; $display("FAIL corner_product i=%0d got=%h want=%h", i, bus.product, tp[i]); end
            checks++;
            if (e !== tp[i]) begin errors++; $display("FAIL corner_model i=%0d got=%h want=%h", i, e, tp[i]); end
        end
    endtask

    task automatic test_mid_calc_start();
        int edges;
        logic [2*L-1:0] e;
        issue(-7, 5);
        @(posedge clk);
        #1;
        bus.word1 = 4'h3;
        bus.word2 = 4'h3;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_ready(edges);
        pop_exp(e);
        checks++;
        if (edges != 2) begin errors++; $display("FAIL midcalc_latency got=%0d want=2", edges); end
        checks++;
        if (bus.product !== e) begin errors++; $display("FAIL midcalc_product got=%h want=%h", bus.product, e); end
`ifdef MBOOTH_ERR_EN
        checks++;
        if (bus.err !== 1'b1) begin errors++; $display("FAIL midcalc_err got=%b want=1", bus.err); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.err !== 1'b1) begin errors++; $display("FAIL midcalc_err_sticky got=%b want=1", bus.err); end
`else
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL midcalc_err got=%b want=0", bus.err); end
`endif
        issue(2, 3);
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL midcalc_err_clear got=%b want=0", bus.err); end
        wait_ready(edges);
        pop_exp(e);
        checks++;
        if (bus.product !== e) begin errors++; $display("FAIL midcalc_next_product got=%h want=%h", bus.product, e); end
    endtask

    task automatic test_back_to_back();
        int oa[3] = '{-8, 6, -3};
        int ob[3] = '{-1, -7, 4};
        int edges;
        logic [31:0] av, bv, p;
        logic [2*L-1:0] e;
        @(negedge clk);
        av = oa[0]; bv = ob[0]; p = oa[0] * ob[0];
        bus.word1 = av[L-1:0];
        bus.word2 = bv[L-1:0];
        bus.start = 1'b1;
        sb.push_back(p[2*L-1:0]);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            wait_ready(edges);
            pop_exp(e);
            checks++;
            if (edges != L) begin errors++; $display("FAIL b2b_latency i=%0d got=%0d want=%0d", i, edges, L); end
            checks++;
            if (bus.product !== e) begin errors++; $display("FAIL b2b_product i=%0d got=%h want=%h", i, bus.product, e); end
            if (i < 2) begin
                av = oa[i+1]; bv = ob[i+1]; p = oa[i+1] * ob[i+1];
                bus.word1 = av[L-1:0];
                bus.word2 = bv[L-1:0];
                sb.push_back(p[2*L-1:0]);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.ready !== (i == 2)) begin errors++; $display("FAIL b2b_ready_width i=%0d got=%b want=%b", i, bus.ready, i == 2); end
        end
    endtask

    task automatic test_reset_mid();
        int edges;
        logic [2*L-1:0] e;
        issue(-5, 3);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        sb.delete();
        checks++;
        if (bus.product !== 8'h00) begin errors++; $display("FAIL rstmid_product got=%h want=00", bus.product); end
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got=%b want=0", bus.ready); end
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b want=0", bus.err); end
        @(negedge clk);
        rst_n = 1'b0;
        issue(5, 6);
        wait_ready(edges);
        pop_exp(e);
        checks++;
        if (edges != L) begin errors++; $display("FAIL rstmid_latency got=%0d want=%0d", edges, L); end
        checks++;
        if (bus.product !== 8'h1E) begin errors++; $display("FAIL rstmid_next_product got=%h want=1e", bus.product); end
        checks++;
        if (e !== 8'h1E) begin errors++; $display("FAIL rstmid_model got=%h want=1e", e); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_corners();
        test_mid_calc_start();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
